// File: rtl/mem_stage.sv
// Memory-access stage: drives one data-memory transaction per load/store, aligns
// and extends load data, traps misaligned/illegal accesses, and emits one write-back record.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic [2:0]  in_funct3,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_exc
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_LD_ALIGN = 2'b01;
    localparam logic [1:0] EXC_ST_ALIGN = 2'b10;
    localparam logic [1:0] EXC_FUNCT3   = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, nxt_state;

    logic            nxt_dmem_req, nxt_dmem_we;
    logic [XLEN-1:0] nxt_dmem_addr, nxt_dmem_wdata;
    logic [3:0]      nxt_dmem_be;
    logic            nxt_wb_valid, nxt_wb_we;
    logic [4:0]      nxt_wb_rd;
    logic [XLEN-1:0] nxt_wb_data;
    logic [1:0]      nxt_wb_exc;

    // Attributes of the in-flight memory op, needed when the response returns
    logic [2:0] op_f3, nxt_op_f3;
    logic [1:0] op_off, nxt_op_off;
    logic       op_load, nxt_op_load;
    logic [4:0] op_rd, nxt_op_rd;

    logic            is_mem, f3_illegal, misaligned;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_be;
    logic [XLEN-1:0] rd_shifted;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] ld_data;

    assign in_ready = (state == IDLE);

    // Accept-time decode of the incoming instruction
    always_comb begin
        is_mem     = in_is_load | in_is_store;
        f3_illegal = is_mem && ((in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11) ||
                                (in_is_store && in_funct3[2]));
        misaligned = is_mem && (((in_funct3[1:0] == 2'b01) && in_alu_result[0]) ||
                                ((in_funct3[1:0] == 2'b10) && (in_alu_result[1:0] != 2'b00)));
        case (in_funct3[1:0])
            2'b00: begin
                st_wdata = {4{in_store_data[7:0]}};
                st_be    = 4'b0001 << in_alu_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{in_store_data[15:0]}};
                st_be    = in_alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = in_store_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        rd_shifted = dmem_rdata >> 5'({op_off, 3'b000});
        rd_byte    = rd_shifted[7:0];
        rd_half    = op_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_f3)
            F3_B:    ld_data = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   ld_data = {24'd0, rd_byte};
            F3_H:    ld_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   ld_data = {16'd0, rd_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        nxt_state      = state;
        nxt_dmem_req   = dmem_req;
        nxt_dmem_we    = dmem_we;
        nxt_dmem_addr  = dmem_addr;
        nxt_dmem_wdata = dmem_wdata;
        nxt_dmem_be    = dmem_be;
        nxt_wb_valid   = 1'b0;
        nxt_wb_we      = wb_we;
        nxt_wb_rd      = wb_rd;
        nxt_wb_data    = wb_data;
        nxt_wb_exc     = wb_exc;
        nxt_op_f3      = op_f3;
        nxt_op_off     = op_off;
        nxt_op_load    = op_load;
        nxt_op_rd      = op_rd;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        nxt_state    = RESP;
                        nxt_wb_valid = 1'b1;
                        nxt_wb_we    = in_rd_we && (in_rd != 5'd0);
                        nxt_wb_rd    = in_rd;
                        nxt_wb_data  = in_alu_result;
                        nxt_wb_exc   = EXC_NONE;
                    end else if (f3_illegal || misaligned) begin
                        nxt_state    = RESP;
                        nxt_wb_valid = 1'b1;
                        nxt_wb_we    = 1'b0;
                        nxt_wb_rd    = in_rd;
                        nxt_wb_data  = '0;
                        if (f3_illegal)
                            nxt_wb_exc = EXC_FUNCT3;
                        else
                            nxt_wb_exc = in_is_load ? EXC_LD_ALIGN : EXC_ST_ALIGN;
                    end else begin
                        nxt_state      = MEM;
                        nxt_dmem_req   = 1'b1;
                        nxt_dmem_we    = in_is_store;
                        nxt_dmem_addr  = {in_alu_result[31:2], 2'b00};
                        nxt_dmem_wdata = in_is_store ? st_wdata : '0;
                        nxt_dmem_be    = in_is_store ? st_be : 4'b1111;
                        nxt_op_f3      = in_funct3;
                        nxt_op_off     = in_alu_result[1:0];
                        nxt_op_load    = in_is_load;
                        nxt_op_rd      = in_rd;
                    end
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    nxt_state    = RESP;
                    nxt_dmem_req = 1'b0;
                    nxt_wb_valid = 1'b1;
                    nxt_wb_rd    = op_rd;
                    nxt_wb_exc   = EXC_NONE;
                    nxt_wb_we    = op_load && (op_rd != 5'd0);
                    nxt_wb_data  = op_load ? ld_data : '0;
                end
            end
            RESP: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_exc     <= '0;
            op_f3      <= '0;
            op_off     <= '0;
            op_load    <= 1'b0;
            op_rd      <= '0;
        end else begin
            state      <= nxt_state;
            dmem_req   <= nxt_dmem_req;
            dmem_we    <= nxt_dmem_we;
            dmem_addr  <= nxt_dmem_addr;
            dmem_wdata <= nxt_dmem_wdata;
            dmem_be    <= nxt_dmem_be;
            wb_valid   <= nxt_wb_valid;
            wb_we      <= nxt_wb_we;
            wb_rd      <= nxt_wb_rd;
            wb_data    <= nxt_wb_data;
            wb_exc     <= nxt_wb_exc;
            op_f3      <= nxt_op_f3;
            op_off     <= nxt_op_off;
            op_load    <= nxt_op_load;
            op_rd      <= nxt_op_rd;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random instructions checked against a
// byte-addressed memory model and an instruction-level result model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_alu_result, in_store_data;
    logic [2:0]  in_funct3;
    logic        in_is_load, in_is_store;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] bmem [logic [31:0]];

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_rd(in_rd), .in_rd_we(in_rd_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : 8'h00;
    endfunction

    function automatic int access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Runs one instruction end to end; waits = cycles with dmem_ready low before completion
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input bit rdwe, input int waits);
        int          n;
        bit          illegal, mis;
        logic [1:0]  exc;
        logic [31:0] waddr, exp_wdata, word, v;
        logic [3:0]  exp_be;
        n       = access_size(f3);
        illegal = (ld || st) && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3 >= 3'd4));
        mis     = (ld || st) && ((addr % n) != 0);
        exc     = illegal ? 2'b11 : (mis ? (ld ? 2'b01 : 2'b10) : 2'b00);

        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_alu_result = addr; in_store_data = sd; in_rd = rd; in_rd_we = rdwe;
        @(posedge clk); #1;
        in_valid = 1'b0;

        if (!(ld || st) || exc != 2'b00) begin
            check("short_req",   32'(dmem_req), 32'd0);
            check("short_valid", 32'(wb_valid), 32'd1);
            check("short_exc",   32'(wb_exc), 32'(exc));
            check("short_we",    32'(wb_we), (ld || st) ? 32'd0 : 32'(rdwe && rd != 0));
            check("short_rd",    32'(wb_rd), 32'(rd));
            if (!(ld || st)) check("short_data", wb_data, addr);
        end else begin
            waddr  = addr & ~32'd3;
            exp_be = 4'b0000;
            exp_wdata = 32'd0;
            word = 32'd0;
            for (int i = 0; i < 4; i++) begin
                if (waddr + i >= addr && waddr + i < addr + n) exp_be[i] = 1'b1;
                exp_wdata[8*i +: 8] = sd[8*(i % n) +: 8];
                word[8*i +: 8] = mem_byte(waddr + i);
            end
            if (ld) exp_be = 4'b1111;
            for (int c = 0; c <= waits; c++) begin
                check("mem_req",   32'(dmem_req), 32'd1);
                check("mem_addr",  dmem_addr, waddr);
                check("mem_we",    32'(dmem_we), 32'(st));
                check("mem_be",    32'(dmem_be), 32'(exp_be));
                if (st) check("mem_wdata", dmem_wdata, exp_wdata);
                check("mem_in_ready", 32'(in_ready), 32'd0);
                check("mem_wb_valid", 32'(wb_valid), 32'd0);
                dmem_ready = (c == waits);
                dmem_rdata = (c == waits) ? word : $urandom;
                @(posedge clk); #1;
                dmem_ready = 1'b0;
            end
            v = 32'd0;
            for (int k = 0; k < n; k++) begin
                if (st) bmem[addr + k] = sd[8*k +: 8];
                v[8*k +: 8] = mem_byte(addr + k);
            end
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            check("resp_req",   32'(dmem_req), 32'd0);
            check("resp_valid", 32'(wb_valid), 32'd1);
            check("resp_exc",   32'(wb_exc), 32'd0);
            check("resp_we",    32'(wb_we), 32'(ld && rd != 0));
            check("resp_rd",    32'(wb_rd), 32'(rd));
            check("resp_data",  wb_data, ld ? v : 32'd0);
        end
        @(posedge clk); #1;
        check("valid_pulse", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        bit          ld, st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind;

        rst = 1'b1; in_valid = 1'b0; in_alu_result = '0; in_store_data = '0;
        in_funct3 = '0; in_is_load = 1'b0; in_is_store = 1'b0; in_rd = '0;
        in_rd_we = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req",      32'(dmem_req), 32'd0);
        check("rst_we",       32'(dmem_we), 32'd0);
        check("rst_addr",     dmem_addr, 32'd0);
        check("rst_wdata",    dmem_wdata, 32'd0);
        check("rst_be",       32'(dmem_be), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_we",    32'(wb_we), 32'd0);
        check("rst_wb_rd",    32'(wb_rd), 32'd0);
        check("rst_wb_data",  wb_data, 32'd0);
        check("rst_wb_exc",   32'(wb_exc), 32'd0);
        rst = 1'b0;

        do_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0);
        do_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd7, 0, 0);
        do_op(0, 1, 3'b000, 32'h203, 32'h12345678, 5'd1, 0, 1);
        do_op(0, 1, 3'b010, 32'h200, 32'h80FF7F80, 5'd0, 0, 0);
        do_op(1, 0, 3'b000, 32'h200, 32'h0, 5'd3, 0, 0);
        do_op(1, 0, 3'b100, 32'h200, 32'h0, 5'd3, 0, 2);
        do_op(1, 0, 3'b001, 32'h202, 32'h0, 5'd4, 0, 0);
        do_op(1, 0, 3'b101, 32'h202, 32'h0, 5'd4, 0, 1);
        do_op(1, 0, 3'b010, 32'h1002, 32'h0, 5'd8, 0, 0);
        do_op(0, 1, 3'b001, 32'h1001, 32'hABCD, 5'd8, 0, 0);
        do_op(1, 0, 3'b111, 32'h100, 32'h0, 5'd9, 0, 0);
        do_op(0, 1, 3'b100, 32'h100, 32'h0, 5'd9, 0, 0);
        do_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd10, 0, 3);
        do_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd0, 0, 3);
        do_op(0, 0, 3'b000, 32'hCAFE0001, 32'h0, 5'd0, 1, 0);

        // Reset while a load waits in MEM abandons it
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
        in_alu_result = 32'h100; in_rd = 5'd6; in_rd_we = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstmem_req_before", 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmem_req",      32'(dmem_req), 32'd0);
        check("rstmem_wb_valid", 32'(wb_valid), 32'd0);
        check("rstmem_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("rstmem_no_valid", 32'(wb_valid), 32'd0);
        do_op(0, 0, 3'b000, 32'h55, 32'h0, 5'd5, 1, 0);

        for (int t = 0; t < 200; t++) begin
            kind = int'($urandom_range(0, 2));
            ld = (kind == 1);
            st = (kind == 2);
            if ($urandom_range(0, 3) != 0) begin
                f3 = 3'($urandom_range(0, 2));
                if (ld && $urandom_range(0, 1) == 1 && f3 != 3'b010) f3[2] = 1'b1;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = 32'h300 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(access_size(f3)) - 32'd1);
            if (kind == 0) a = $urandom;
            do_op(ld, st, f3, a, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RISC-V core, directly downstream of the ALU. It takes the ALU result, used as the effective address for loads and stores or passed through otherwise, and performs the data-memory transaction over a req/ready handshake. It then aligns and extends load data and presents one write-back record per instruction. Misaligned accesses and illegal load/store widths are trapped here without touching memory.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: upstream holds a valid instruction.
- `in_ready` output 1: stage can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_alu_result` input 32: ALU output; effective address for memory ops.
- `in_store_data` input 32: rs2 value for stores.
- `in_funct3` input 3: width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `in_is_load`, `in_is_store` input 1 each: at most one set.
- `in_rd` input 5: destination register.
- `in_rd_we` input 1: non-memory op writes `rd`.
- `dmem_req` output 1: memory request.
- `dmem_we` output 1: 1 for store.
- `dmem_addr` output 32: word-aligned address.
- `dmem_wdata` output 32: lane-replicated store data.
- `dmem_be` output 4: byte enables.
- `dmem_ready` input 1: memory completes the request this edge.
- `dmem_rdata` input 32: read word, valid when `dmem_ready`.
- `wb_valid` output 1: write-back record valid, exactly one cycle per accepted instruction.
- `wb_we`, `wb_rd` (5), `wb_data` (32) output: register write request.
- `wb_exc` output 2: 00 none, 01 misaligned load, 10 misaligned store, 11 illegal funct3 on a memory op.

## Operation
- FSM states IDLE, MEM, RESP. `in_ready = (state == IDLE)`.
- Transitions from IDLE, on accept:
  - Non-memory op -> RESP with `wb_data = in_alu_result` and `wb_we = in_rd_we && rd != 0`.
  - Memory op with illegal funct3 (011, 110, 111, or 100/101 on a store) -> RESP with the matching `wb_exc`.
  - Misaligned memory op -> RESP with the matching `wb_exc`. Misaligned means H with `addr[0] = 1`, or W with `addr[1:0] != 0`.
  - Any exception: `wb_we = 0` and no `dmem_req` is issued.
  - Otherwise -> MEM.
- Store driving (all dmem outputs registered at accept):
  - `dmem_addr = {addr[31:2], 2'b00}`.
  - SB: `wdata = {4{sd[7:0]}}`, `be = 4'b0001 << addr[1:0]`.
  - SH: `wdata = {2{sd[15:0]}}`, `be = addr[1] ? 1100 : 0011`.
  - SW: `wdata = sd`, `be = 1111`.
- Load driving: `dmem_we = 0`, `be = 1111`.
- MEM: `dmem_req = 1`. Hold `dmem_addr/we/wdata/be` stable until `dmem_ready` is sampled high, then -> RESP.
- Load result at the `dmem_ready` edge:
  - Select byte `addr[1:0]` or half `addr[1]`; sign-extend for B/H, zero-extend for BU/HU.
  - `wb_we = (rd != 0)`.
- Store result: `wb_we = 0` and `wb_data = 0`.
- RESP: `wb_valid = 1` for one cycle, then -> IDLE. `wb_*` hold their values until the next RESP; consumers use them only while `wb_valid`.
- `dmem_ready` is ignored while `dmem_req = 0`.

## Timing
- Reset values: state IDLE, `dmem_req = 0`, `dmem_we = 0`, `dmem_addr = 0`, `dmem_wdata = 0`, `dmem_be = 0`, `wb_valid = 0`, `wb_we = 0`, `wb_rd = 0`, `wb_data = 0`, `wb_exc = 0`, so `in_ready = 1`.
- Non-memory or exception, accepted at edge E: `wb_valid` is high in the cycle after E. Throughput is one instruction per 2 cycles.
- Memory op accepted at edge E: `dmem_req` is high from E until the edge where `dmem_ready = 1`, at least one cycle. `wb_valid` is high in the cycle after that edge.
- With zero-wait memory (`dmem_ready` tied high): 2 cycles from accept to `wb_valid`, 3 cycles per instruction.
- `rst` asserted in any state: the next edge forces reset values. An in-flight request is abandoned: `req` drops and no `wb_valid` is produced.
- `in_valid` while not in IDLE: no transfer; upstream holds its inputs.

## Test plan
- SW `0xDEADBEEF` to `0x100`, then LW `0x100` with memory model -> `be = 1111`, `addr = 0x100`; LW gives `wb_data = 0xDEADBEEF`, `wb_we = 1`.
- SB `0x12345678` to `0x203` -> `dmem_addr = 0x200`, `be = 1000`, `wdata = 0x78787878`, `wb_we = 0`, `wb_valid` pulses once.
- Memory word `0x80FF7F80`: LB `0x200` -> `0xFFFFFF80`; LBU `0x200` -> `0x00000080`; LH `0x202` -> `0xFFFF80FF`; LHU `0x202` -> `0x000080FF`.
- LW `0x1002` -> no `dmem_req`, `wb_exc = 01`, `wb_we = 0`. SH `0x1001` -> `wb_exc = 10`. Load with funct3 111 -> `wb_exc = 11`.
- LW with `dmem_ready` low for 3 cycles -> `dmem_req` and address stable for 4 cycles, `in_ready = 0` throughout, single `wb_valid` after ready. Repeat with rd = 0 -> `wb_we = 0`.
- `rst` pulsed in MEM -> `dmem_req = 0` next cycle, no `wb_valid`, `in_ready = 1`; the next ALU passthrough (`0x55`, rd 5) gives `wb_data = 0x55`, `wb_we = 1`.
